// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package md_defs;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  function automatic logic md_is_multicycle(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_arith.sv
// Combinational multiply/divide datapath. Signed division is done on
// magnitudes so the most-negative / -1 case wraps to most-negative naturally.
module md_arith
  import md_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + ONE;
  endfunction

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic                      signed_div;
  logic                      a_neg;
  logic                      b_neg;
  logic        [WIDTH-1:0]   a_mag;
  logic        [WIDTH-1:0]   b_mag;
  logic        [WIDTH-1:0]   divisor;
  logic        [WIDTH-1:0]   q_mag;
  logic        [WIDTH-1:0]   r_mag;

  assign prod_s = $signed({{WIDTH{in1[WIDTH-1]}}, in1}) * $signed({{WIDTH{in2[WIDTH-1]}}, in2});
  assign prod_u = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};

  assign signed_div = (op == MD_DIV);
  assign a_neg      = signed_div & in1[WIDTH-1];
  assign b_neg      = signed_div & in2[WIDTH-1];
  assign a_mag      = a_neg ? negate(in1) : in1;
  assign b_mag      = b_neg ? negate(in2) : in2;
  assign div_zero   = (in2 == '0);
  // Substitute a divisor of 1 so the unused quotient never goes X.
  assign divisor    = div_zero ? ONE : b_mag;
  assign q_mag      = a_mag / divisor;
  assign r_mag      = a_mag % divisor;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        res_lo = (a_neg ^ b_neg) ? negate(q_mag) : q_mag;
        res_hi = a_neg ? negate(r_mag) : r_mag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO. Results are computed at launch into
// shadow registers and committed after a fixed busy window.
module md_unit
  import md_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] sh_hi_q, sh_hi_d;
  logic [WIDTH-1:0] sh_lo_q, sh_lo_d;
  logic             sh_dz_q, sh_dz_d;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;
  logic             accept;
  logic             is_div;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .in1      (in1),
    .in2      (in2),
    .op       (op),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign accept = (state_q == IDLE) && start && !cancel;
  assign is_div = (op == MD_DIV) || (op == MD_DIVU);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_dz_d = sh_dz_q;
    case (state_q)
      IDLE: begin
        if (accept && md_is_multicycle(op)) begin
          state_d = RUN;
          cnt_d   = is_div ? DIV_CNT : MULT_CNT;
          sh_hi_d = res_hi;
          sh_lo_d = res_lo;
          sh_dz_d = is_div && div_zero;
        end else if (accept && (op == MD_MTHI)) begin
          hi_d = in1;
        end else if (accept && (op == MD_MTLO)) begin
          lo_d = in1;
        end
      end
      RUN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          // Divide-by-zero burns the full latency but leaves HI/LO alone.
          if (!sh_dz_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Shadow results are only consumed in RUN, so they need no reset.
  always_ff @(posedge clk) begin
    sh_hi_q <= sh_hi_d;
    sh_lo_q <= sh_lo_d;
    sh_dz_q <= sh_dz_d;
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core; sits in the E stage beside the ALU.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU over a configurable multi-cycle latency.
- Exports busy for the hazard unit, and honours an exception-flush cancel so a faulting or interrupted instruction never alters HI/LO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch strobe from E stage, one cycle.
- op  in  4  operation code (package md_defs).
- in1  in  WIDTH  rs operand / dividend / MTHI-MTLO data.
- in2  in  WIDTH  rt operand / divisor.
- cancel  in  1  exception/interrupt flush of the E-stage instruction this cycle.
- busy  out  1  operation in flight.
- hi  out  WIDTH  HI register (MFHI source).
- lo  out  WIDTH  LO register (MFLO source).

Behaviour:
- One clock `clk`; reset is synchronous and active-high on `reset`.
- Reset: hi=0, lo=0, busy=0, state=IDLE, counter=0, shadow results discarded. Applies even mid-operation.
- Ops: MULT, MULTU, DIV, DIVU, MTHI, MTLO, NOP. The pipeline uses MFHI/MFLO by reading hi/lo directly; there is no op for them.
- State IDLE, accept condition: start=1, cancel=0, and op is in {MULT, MULTU, DIV, DIVU}.
  - Latch the full result into shadow registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- State RUN:
  - Counter decrements each cycle.
  - On the edge where the counter reaches 1, write hi/lo from shadow, drop busy, return to IDLE.
  - Launched at edge T0 means busy is high for cycles T0+1 .. T0+N, and the new hi/lo are visible in the cycle after edge T0+N.
- Hazard unit stalls on (start & mult/div op) | busy. start while busy is ignored.
- MTHI/MTLO: in IDLE with start=1 and cancel=0, write in1 to hi or lo at the edge. Zero latency; busy stays 0. Ignored in RUN.
- cancel:
  - Suppresses launch and MT writes in the same cycle.
  - No effect on an operation already in RUN, which belongs to an older, committed instruction.
- Arithmetic:
  - MULT: signed 2*WIDTH product, {hi,lo} = product.
  - MULTU: same product, unsigned.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
  - Divisor 0: busy runs the full DIV_CYCLES, but hi/lo are left unchanged at completion.
- hi/lo outputs are registered; there is no combinational path from in1/in2 to hi/lo.
- No ExcCode output: MD ops raise no exceptions.

Decomposition:
- Package md_defs: op encodings (MD_NOP=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6), state enum {IDLE, RUN}, default latencies.
- Sub-module md_arith: purely combinational. Takes in1, in2 and op; returns {res_hi, res_lo, div_zero}.
- md_unit keeps the FSM, counter, shadow registers and HI/LO.

Test Plan:
- MULT in1=0xFFFFFFFF, in2=0x2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x1, lo=0xFFFFFFFE.
- DIV in1=0xFFFFFFF9 (-7), in2=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 with hi previously 0 -> hi=0x1234 next cycle, busy never asserts. DIVU x/0 after that -> busy 10 cycles, hi=0x1234 unchanged.
- start=1 with cancel=1, op=MULT -> busy stays 0, hi/lo unchanged. cancel raised on cycle 2 of a running MULT -> result still written at cycle 5.
- reset on cycle 3 of a DIV -> next cycle busy=0, hi=lo=0, and no later write-back occurs. start pulsed again during RUN -> ignored, original result written.
- Override MULT_CYCLES=1, DIV_CYCLES=1 -> busy is high exactly one cycle and results are correct, checking the counter boundary.
